// File: rtl/ram128_delay_line_pkg.sv
// Shared sizing constants and pointer-advance helper for the LUTRAM delay line.
package ram128_delay_line_pkg;

   localparam int unsigned DL_PTR_W     = 7;
   localparam int unsigned DL_FILL_W    = 8;
   localparam int unsigned DL_MAX_DEPTH = 128;

   // Circular pointer that wraps at the programmed length rather than at the RAM depth.
   function automatic logic [DL_PTR_W-1:0] dl_next_ptr(input logic [DL_PTR_W-1:0] ptr,
                                                        input logic [DL_PTR_W-1:0] len);
      return (ptr == len) ? '0 : ptr + DL_PTR_W'(1);
   endfunction

endpackage

// File: rtl/RAM128X1S.sv
// Behavioural model of a 128x1 single-port LUTRAM: asynchronous read, synchronous write.
module RAM128X1S
   import ram128_delay_line_pkg::*;
#(
   parameter logic [DL_MAX_DEPTH-1:0] INIT = '0
) (
   output logic                O,
   input  logic [DL_PTR_W-1:0] A,
   input  logic                D,
   input  logic                WCLK,
   input  logic                WE
);

   // Power-up contents come from the configuration bitstream; there is no reset.
   logic [DL_MAX_DEPTH-1:0] mem = INIT;

   assign O = mem[A];

   always_ff @(posedge WCLK) begin
      if (WE) begin
         mem[A] <= D;
      end
   end

endmodule

// File: rtl/ram128_delay_line.sv
// Programmable 1..128 sample delay line built from WIDTH LUTRAM bit-slices sharing one address.
module ram128_delay_line
   import ram128_delay_line_pkg::*;
#(
   parameter int unsigned          WIDTH    = 8,
   parameter logic [DL_PTR_W-1:0]  INIT_LEN = 7'd127
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [DL_PTR_W-1:0] LEN,
   input  logic                LEN_LD,
   input  logic                EN,
   input  logic [WIDTH-1:0]    DIN,
   output logic [WIDTH-1:0]    DOUT,
   output logic                DOUT_VLD,
   output logic                FILLED
);

   logic [DL_PTR_W-1:0]  ptr_q;
   logic [DL_PTR_W-1:0]  len_q;
   logic [DL_FILL_W-1:0] fill_q;
   logic [DL_FILL_W-1:0] fill_d;
   logic [DL_FILL_W-1:0] depth;
   logic [WIDTH-1:0]     dout_q;
   logic                 dout_vld_q;
   logic                 filled_q;
   logic [WIDTH-1:0]     ram_rd;
   logic                 we;

   assign we = EN & ~RST & ~LEN_LD;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      RAM128X1S #(
         .INIT (128'h0)
      ) u_ram (
         .O    (ram_rd[i]),
         .A    (ptr_q),
         .D    (DIN[i]),
         .WCLK (CLK),
         .WE   (we)
      );
   end

   // Fill count saturates at the programmed depth; 8 bits so a depth of 128 is representable.
   always_comb begin
      depth  = DL_FILL_W'(len_q) + DL_FILL_W'(1);
      fill_d = fill_q;
      if (fill_q < depth) begin
         fill_d = fill_q + DL_FILL_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q      <= '0;
         fill_q     <= '0;
         len_q      <= INIT_LEN;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         filled_q   <= 1'b0;
      end else if (LEN_LD) begin
         len_q      <= LEN;
         ptr_q      <= '0;
         fill_q     <= '0;
         filled_q   <= 1'b0;
         dout_vld_q <= 1'b0;
      end else if (EN) begin
         dout_q     <= ram_rd;
         dout_vld_q <= filled_q;
         ptr_q      <= dl_next_ptr(ptr_q, len_q);
         fill_q     <= fill_d;
         filled_q   <= (fill_d >= depth);
      end else begin
         dout_vld_q <= 1'b0;
      end
   end

   assign DOUT     = dout_q;
   assign DOUT_VLD = dout_vld_q;
   assign FILLED   = filled_q;

endmodule
